// File: rtl/bit_pattern_tx.sv
// Serialises a latched pattern onto d_out, repeating it load_repeat+1 times
// with GAP_CYCLES idle cycles between repeats and a done pulse at the end.
module bit_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter int LSB_FIRST  = 0,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [3:0]       load_repeat,
  input  logic             abort,
  output logic             d_out,
  output logic             d_valid,
  output logic             busy,
  output logic             done
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]     LAST_GAP = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  pattern_reg;
  logic [WIDTH-1:0]  shift_reg;
  logic [WIDTH-1:0]  shift_next;
  logic [3:0]        rep_cnt_reg;
  logic [3:0]        gap_cnt_reg;
  logic [CW-1:0]     bit_cnt_reg;
  logic              accept;

  // The bit that goes on the wire first for a given register image.
  function automatic logic lead_bit(input logic [WIDTH-1:0] v);
    if (LSB_FIRST != 0) return v[0];
    else                return v[WIDTH-1];
  endfunction

  always_comb begin
    shift_next = (LSB_FIRST != 0) ? (shift_reg >> 1) : (shift_reg << 1);
  end

  assign load_ready = (state_reg == IDLE) && !abort && reset;
  assign accept     = load_valid && load_ready;
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pattern_reg <= '0;
      shift_reg   <= '0;
      rep_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      d_out       <= 1'b0;
      d_valid     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg   <= SHIFT;
            pattern_reg <= load_data;
            shift_reg   <= load_data;
            rep_cnt_reg <= load_repeat;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            d_out       <= lead_bit(load_data);
            d_valid     <= 1'b1;
          end
        end

        SHIFT: begin
          if (abort) begin
            state_reg   <= IDLE;
            rep_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            d_out       <= 1'b0;
            d_valid     <= 1'b0;
          end else if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_reg <= '0;
            if (rep_cnt_reg == 4'd0) begin
              state_reg <= IDLE;
              d_out     <= 1'b0;
              d_valid   <= 1'b0;
              done      <= 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state_reg   <= GAP;
              rep_cnt_reg <= rep_cnt_reg - 4'd1;
              gap_cnt_reg <= '0;
              d_out       <= 1'b0;
              d_valid     <= 1'b0;
            end else begin
              // No gap: the next repeat starts on the very next cycle.
              rep_cnt_reg <= rep_cnt_reg - 4'd1;
              shift_reg   <= pattern_reg;
              d_out       <= lead_bit(pattern_reg);
              d_valid     <= 1'b1;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            shift_reg   <= shift_next;
            d_out       <= lead_bit(shift_next);
          end
        end

        GAP: begin
          if (abort) begin
            state_reg   <= IDLE;
            rep_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            d_out       <= 1'b0;
            d_valid     <= 1'b0;
          end else if (gap_cnt_reg == LAST_GAP) begin
            state_reg   <= SHIFT;
            gap_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= pattern_reg;
            d_out       <= lead_bit(pattern_reg);
            d_valid     <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 4'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          d_out     <= 1'b0;
          d_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_pattern_tx.sv
// Two transmitters (MSB-first with a 1-cycle gap, LSB-first with no gap) share
// the same stimulus; each is compared cycle by cycle with its expected stream.
module tb_bit_pattern_tx;

  typedef struct packed {
    logic dv;
    logic dout;
    logic busy;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic       abort;
  logic [7:0] load_data;
  logic [3:0] load_repeat;
  logic [1:0] load_ready_w, d_out_w, d_valid_w, busy_w, done_w;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t expq[2][$];

  bit_pattern_tx #(.WIDTH(8), .LSB_FIRST(0), .GAP_CYCLES(1)) dut_msb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_w[0]),
    .load_data(load_data), .load_repeat(load_repeat), .abort(abort),
    .d_out(d_out_w[0]), .d_valid(d_valid_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  bit_pattern_tx #(.WIDTH(8), .LSB_FIRST(1), .GAP_CYCLES(0)) dut_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_w[1]),
    .load_data(load_data), .load_repeat(load_repeat), .abort(abort),
    .d_out(d_out_w[1]), .d_valid(d_valid_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  // Expected per-cycle stream for one transaction, starting the cycle after accept.
  task automatic gen(input int k, input int lsb, input int gap, input logic [7:0] data,
                     input int rep, input int abort_at);
    exp_t tmp[$];
    exp_t e;
    for (int r = 0; r <= rep; r++) begin
      for (int i = 0; i < 8; i++) begin
        e.dv = 1'b1; e.busy = 1'b1; e.done = 1'b0;
        e.dout = (lsb != 0) ? data[i] : data[7-i];
        tmp.push_back(e);
      end
      if (r < rep)
        for (int g = 0; g < gap; g++) tmp.push_back(exp_t'(4'b0010));
    end
    tmp.push_back(exp_t'(4'b0001));
    if (abort_at >= 0)
      while (tmp.size() > abort_at + 1) void'(tmp.pop_back());
    foreach (tmp[i]) expq[k].push_back(tmp[i]);
  endtask

  task automatic gen_both(input logic [7:0] data, input int rep, input int abort_at);
    gen(0, 0, 1, data, rep, abort_at);
    gen(1, 1, 0, data, rep, abort_at);
  endtask

  task automatic check_idle_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s dut%0d d_out", tag, k), d_out_w[k], 1'b0);
      check($sformatf("%s dut%0d d_valid", tag, k), d_valid_w[k], 1'b0);
      check($sformatf("%s dut%0d busy", tag, k), busy_w[k], 1'b0);
      check($sformatf("%s dut%0d done", tag, k), done_w[k], 1'b0);
      check($sformatf("%s dut%0d load_ready", tag, k), load_ready_w[k], 1'b0);
    end
  endtask

  task automatic start(input logic [7:0] data, input logic [3:0] rep, input bit hold);
    @(negedge clk);
    load_valid  = 1'b1;
    load_data   = data;
    load_repeat = rep;
    @(posedge clk);
    #1;
    if (!hold) begin
      load_valid  = 1'b0;
      load_data   = 8'($urandom);
      load_repeat = 4'($urandom);
    end
  endtask

  task automatic run_cycles(input string name, input int n, input int abort_at, input int drop_at);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        e = (expq[k].size() > 0) ? expq[k].pop_front() : exp_t'(4'b0000);
        check($sformatf("%s dut%0d c%0d d_valid", name, k, c), d_valid_w[k], e.dv);
        check($sformatf("%s dut%0d c%0d d_out", name, k, c), d_out_w[k], e.dout);
        check($sformatf("%s dut%0d c%0d busy", name, k, c), busy_w[k], e.busy);
        check($sformatf("%s dut%0d c%0d done", name, k, c), done_w[k], e.done);
        check($sformatf("%s dut%0d c%0d load_ready", name, k, c), load_ready_w[k], !e.busy);
      end
      abort = (c == abort_at);
      @(posedge clk);
      #1;
      abort = 1'b0;
      if (c == drop_at) load_valid = 1'b0;
    end
  endtask

  task automatic run(input string name, input int abort_at, input int drop_at);
    int n;
    n = (expq[0].size() > expq[1].size()) ? expq[0].size() : expq[1].size();
    run_cycles(name, n + 2, abort_at, drop_at);
  endtask

  initial begin
    logic [7:0] rd;
    int rr, ra;
    reset = 1'b1; load_valid = 1'b0; abort = 1'b0; load_data = '0; load_repeat = '0;
    #1 reset = 1'b0;
    #1 check_idle_reset("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    gen_both(8'hA5, 0, -1); start(8'hA5, 4'd0, 0); run("a5", -1, -1);
    gen_both(8'hC3, 1, -1); start(8'hC3, 4'd1, 0); run("c3", -1, -1);
    gen_both(8'h01, 0, -1); start(8'h01, 4'd0, 0); run("01", -1, -1);
    gen_both(8'hFF, 0, 2);  start(8'hFF, 4'd0, 0); run("abort", 2, -1);

    // Held load_valid: second pattern is taken on the done cycle.
    gen_both(8'hAA, 0, -1); gen_both(8'hAA, 0, -1);
    start(8'hAA, 4'd0, 1); run("hold", -1, 8);

    for (int t = 0; t < 8; t++) begin
      rd = 8'($urandom);
      rr = $urandom_range(0, 3);
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      gen_both(rd, rr, ra); start(rd, 4'(rr), 0);
      run($sformatf("rand%0d", t), ra, -1);
    end

    // Asynchronous reset mid-shift, then the first edge after release accepts.
    gen_both(8'h3C, 2, -1); start(8'h3C, 4'd2, 0);
    run_cycles("pre_rst", 4, -1, -1);
    #2 reset = 1'b0;
    #1 check_idle_reset("async_rst");
    expq[0].delete(); expq[1].delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; load_valid = 1'b1; load_data = 8'h5A; load_repeat = 4'd0;
    @(posedge clk);
    #1 load_valid = 1'b0; load_data = 8'($urandom); load_repeat = 4'($urandom);
    gen_both(8'h5A, 0, -1); run("5a", -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
